// File: rtl/hdlc_rx_frame_buffer_pkg.sv
// Shared types and default constants for the HDLC receive frame buffer.
package hdlc_rxbuf_pkg;

  typedef enum logic [0:0] {
    RXB_FILL  = 1'b0,
    RXB_READY = 1'b1
  } rxb_state_e;

  localparam int RXB_DATA_W             = 8;
  localparam int RXB_DEPTH              = 128;
  localparam int RXB_FCS_BYTES          = 2;
  localparam int RXB_ALMOST_FULL_MARGIN = 4;

endpackage

// File: rtl/hdlc_rx_frame_buffer_if.sv
// Handshake/data bundle between the Rx framer side and the register side of
// the receive frame buffer. Fill-level outputs exist only when
// HDLC_RXBUF_FILL_LEVEL_EN is defined.
interface hdlc_rx_frame_buffer_if #(
  parameter int DATA_W = 8,
  parameter int SIZE_W = 8
);

  logic              Rx_NewByte;
  logic [DATA_W-1:0] Rx_Data;
  logic              Rx_EoF;
  logic              Rx_FrameError;
  logic              Rx_AbortSignal;
  logic              Rx_Drop;
  logic              Rx_RdBuff;
  logic [DATA_W-1:0] Rx_DataBuff;
  logic              Rx_Ready;
  logic [SIZE_W-1:0] Rx_FrameSize;
  logic              Rx_Overflow;
`ifdef HDLC_RXBUF_FILL_LEVEL_EN
  logic [SIZE_W-1:0] Rx_FillLevel;
  logic              Rx_AlmostFull;
`endif

  // Buffer side
  modport slave (
    input  Rx_NewByte, Rx_Data, Rx_EoF, Rx_FrameError, Rx_AbortSignal,
           Rx_Drop, Rx_RdBuff,
`ifdef HDLC_RXBUF_FILL_LEVEL_EN
    output Rx_FillLevel, Rx_AlmostFull,
`endif
    output Rx_DataBuff, Rx_Ready, Rx_FrameSize, Rx_Overflow
  );

  // Framer / register-interface side
  modport master (
    output Rx_NewByte, Rx_Data, Rx_EoF, Rx_FrameError, Rx_AbortSignal,
           Rx_Drop, Rx_RdBuff,
`ifdef HDLC_RXBUF_FILL_LEVEL_EN
    input  Rx_FillLevel, Rx_AlmostFull,
`endif
    input  Rx_DataBuff, Rx_Ready, Rx_FrameSize, Rx_Overflow
  );

endinterface

// File: rtl/hdlc_rx_frame_buffer_ram.sv
// Frame storage: DEPTH x DATA_W register array with one synchronous write
// port and one registered read port. Contents are never reset; only the
// read data register is.
module hdlc_rxbuf_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the incoming word at the given address
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle latency, holds value when not reading
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hdlc_rx_frame_buffer.sv
// HDLC receive frame buffer: captures one frame, reports its payload length
// (FCS words excluded), flags lost words, and serves byte-wise readout with
// drop/abort/error discard. Optional fill-level outputs are enabled by
// defining HDLC_RXBUF_FILL_LEVEL_EN.
module hdlc_rx_frame_buffer
  import hdlc_rxbuf_pkg::*;
#(
  parameter int DATA_W    = RXB_DATA_W,
  parameter int DEPTH     = RXB_DEPTH,
  parameter int FCS_BYTES = RXB_FCS_BYTES,
  parameter int SIZE_W    = $clog2(DEPTH+1)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hdlc_rx_frame_buffer_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_FILL  = RXB_FILL;
  localparam logic [0:0] S_READY = RXB_READY;

  logic [0:0]        state;
  logic [SIZE_W-1:0] count;
  logic [SIZE_W-1:0] count_nx;
  logic [SIZE_W-1:0] rptr;
  logic [SIZE_W-1:0] frame_size;
  logic              ready;
  logic              overflow;

  logic              in_fill;
  logic              discard;
  logic              full;
  logic              wr_en;
  logic              rd_en;
  logic              ovf_set;
  logic              ovf_clr;

  // Payload length once the trailing FCS words are removed; only called
  // when the count is known to exceed FCS_BYTES, so it never underflows.
  function automatic logic [SIZE_W-1:0] payload_len(input logic [SIZE_W-1:0] c);
    return c - SIZE_W'(FCS_BYTES);
  endfunction

  assign in_fill  = (state == S_FILL);
  assign discard  = bus.Rx_FrameError | bus.Rx_AbortSignal;
  assign full     = (int'(count) >= DEPTH);
  assign wr_en    = in_fill & bus.Rx_NewByte & ~discard & ~full;
  assign count_nx = count + {{(SIZE_W-1){1'b0}}, wr_en};
  assign ovf_set  = in_fill & bus.Rx_NewByte & ~discard & full;
  assign ovf_clr  = wr_en & (count == '0);
  assign rd_en    = ~in_fill & bus.Rx_RdBuff & ~bus.Rx_Drop;

  hdlc_rxbuf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (Clk),
    .rst   (Rst),
    .we    (wr_en),
    .waddr (count[AW-1:0]),
    .wdata (bus.Rx_Data),
    .re    (rd_en),
    .raddr (rptr[AW-1:0]),
    .rdata (bus.Rx_DataBuff)
  );

  // Frame capture / readout control
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_FILL;
      count      <= '0;
      rptr       <= '0;
      frame_size <= '0;
      ready      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          // A set always wins over a clear in the same cycle
          if (ovf_set)      overflow <= 1'b1;
          else if (ovf_clr) overflow <= 1'b0;

          if (discard) begin
            count <= '0;
          end else if (bus.Rx_EoF) begin
            if (int'(count_nx) > FCS_BYTES) begin
              frame_size <= payload_len(count_nx);
              ready      <= 1'b1;
              rptr       <= '0;
              count      <= count_nx;
              state      <= S_READY;
            end else begin
              count <= '0;
            end
          end else begin
            count <= count_nx;
          end
        end

        S_READY: begin
          // Only one frame is held; anything arriving now is lost
          if (bus.Rx_NewByte) overflow <= 1'b1;

          if (bus.Rx_Drop) begin
            ready      <= 1'b0;
            frame_size <= '0;
            count      <= '0;
            state      <= S_FILL;
          end else if (bus.Rx_RdBuff) begin
            rptr <= rptr + 1'b1;
            if (rptr == frame_size - 1'b1) begin
              ready      <= 1'b0;
              frame_size <= '0;
              count      <= '0;
              state      <= S_FILL;
            end
          end
        end

        default: state <= S_FILL;
      endcase
    end
  end

  assign bus.Rx_Ready     = ready;
  assign bus.Rx_FrameSize = frame_size;
  assign bus.Rx_Overflow  = overflow;

`ifdef HDLC_RXBUF_FILL_LEVEL_EN
  assign bus.Rx_FillLevel  = in_fill ? count : '0;
  assign bus.Rx_AlmostFull = in_fill & (int'(count) >= DEPTH - RXB_ALMOST_FULL_MARGIN);
`endif

endmodule

// File: tb/tb_hdlc_rx_frame_buffer.sv
// Self-checking bench for hdlc_rx_frame_buffer (DEPTH=128, FCS_BYTES=2).
module tb_hdlc_rx_frame_buffer;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  hdlc_rx_frame_buffer_if #(.DATA_W(8), .SIZE_W(8)) bus ();

  hdlc_rx_frame_buffer #(
    .DATA_W    (8),
    .DEPTH     (128),
    .FCS_BYTES (2)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q [$];

  typedef struct {
    logic       nb;
    logic [7:0] d;
    logic       eof;
    logic       rd;
    logic [7:0] exp_d;
    logic       exp_rdy;
    logic [7:0] exp_size;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic nb, input logic [7:0] d, input logic eof,
                       input logic ferr, input logic abrt, input logic drop,
                       input logic rd);
    bus.Rx_NewByte     = nb;
    bus.Rx_Data        = d;
    bus.Rx_EoF         = eof;
    bus.Rx_FrameError  = ferr;
    bus.Rx_AbortSignal = abrt;
    bus.Rx_Drop        = drop;
    bus.Rx_RdBuff      = rd;
    @(posedge Clk);
    #1;
    bus.Rx_NewByte     = 1'b0;
    bus.Rx_EoF         = 1'b0;
    bus.Rx_FrameError  = 1'b0;
    bus.Rx_AbortSignal = 1'b0;
    bus.Rx_Drop        = 1'b0;
    bus.Rx_RdBuff      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_eof();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, bus.Rx_DataBuff);
    end else begin
      e = sb_q.pop_front();
      check(name, 32'(bus.Rx_DataBuff), 32'(e));
    end
  endtask

  task automatic read_exp(input logic [7:0] e, input string name);
    sb_q.push_back(e);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check(name);
  endtask

  task automatic check_status(input string tag, input logic rdy,
                              input logic [7:0] size, input logic ovf);
    check({tag, "_ready"}, 32'(bus.Rx_Ready), 32'(rdy));
    check({tag, "_size"},  32'(bus.Rx_FrameSize), 32'(size));
    check({tag, "_ovf"},   32'(bus.Rx_Overflow), 32'(ovf));
  endtask

  // Assert reset away from the clock edge and check outputs before the next edge
  task automatic async_reset(input string tag);
    #2;
    Rst = 1'b1;
    #1;
    check_status(tag, 1'b0, 8'd0, 1'b0);
    check({tag, "_data"}, 32'(bus.Rx_DataBuff), 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'd3, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 8'd3, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 8'd3, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 8'd0, 1'b0};

    bus.Rx_NewByte     = 1'b0;
    bus.Rx_Data        = 8'h00;
    bus.Rx_EoF         = 1'b0;
    bus.Rx_FrameError  = 1'b0;
    bus.Rx_AbortSignal = 1'b0;
    bus.Rx_Drop        = 1'b0;
    bus.Rx_RdBuff      = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check_status("reset", 1'b0, 8'd0, 1'b0);
    check("reset_data", 32'(bus.Rx_DataBuff), 32'h0);
    @(negedge Clk);
    Rst = 1'b0;

    // Test 1: table-driven basic frame and readout
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rd) sb_q.push_back(tbl[i].exp_d);
      drive(tbl[i].nb, tbl[i].d, tbl[i].eof, 1'b0, 1'b0, 1'b0, tbl[i].rd);
      if (tbl[i].rd) pop_check($sformatf("t1_row%0d_data", i));
      check_status($sformatf("t1_row%0d", i), tbl[i].exp_rdy, tbl[i].exp_size, tbl[i].exp_ovf);
    end

    // Test 2: overflow with truncated delivery
    for (int i = 0; i < 130; i++) begin
      send_byte(8'(i));
      if (i == 127) check("t2_ovf_at_128", 32'(bus.Rx_Overflow), 32'h0);
      if (i == 128) check("t2_ovf_at_129", 32'(bus.Rx_Overflow), 32'h1);
    end
    send_eof();
    check_status("t2_eof", 1'b1, 8'd126, 1'b1);
    for (int i = 0; i < 126; i++) read_exp(8'(i), $sformatf("t2_rd%0d", i));
    check_status("t2_done", 1'b0, 8'd0, 1'b1);

    // Test 3: abort, short frame discard, minimal frame
    send_byte(8'h01);
    check("t3_ovf_clear", 32'(bus.Rx_Overflow), 32'h0);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_abort_ready", 32'(bus.Rx_Ready), 32'h0);
    send_byte(8'h05);
    send_byte(8'h06);
    send_eof();
    check_status("t3_short", 1'b0, 8'd0, 1'b0);
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_eof();
    check_status("t3_min", 1'b1, 8'd1, 1'b0);
    read_exp(8'hA0, "t3_rd0");
    check("t3_done_ready", 32'(bus.Rx_Ready), 32'h0);

    // Test 4: drop beats a same-cycle read; reads in FILL are ignored
    for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i));
    send_eof();
    check_status("t4_eof", 1'b1, 8'd3, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_status("t4_drop", 1'b0, 8'd0, 1'b0);
    check("t4_drop_data", 32'(bus.Rx_DataBuff), 32'hA0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_fill_rd_data", 32'(bus.Rx_DataBuff), 32'hA0);
    check("t4_fill_rd_ready", 32'(bus.Rx_Ready), 32'h0);

    // Test 5: new word while a frame is pending
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
    send_eof();
    check_status("t5_eof", 1'b1, 8'd3, 1'b0);
    send_byte(8'h7E);
    check_status("t5_lost", 1'b1, 8'd3, 1'b1);
    read_exp(8'hC0, "t5_rd0");
    read_exp(8'hC1, "t5_rd1");
    read_exp(8'hC2, "t5_rd2");
    check("t5_done_ready", 32'(bus.Rx_Ready), 32'h0);

    // Test 6a: async reset with a pending, overflowed frame
    for (int i = 0; i < 10; i++) send_byte(8'hD0 + 8'(i));
    send_eof();
    check_status("t6a_eof", 1'b1, 8'd8, 1'b0);
    send_byte(8'h5A);
    read_exp(8'hD0, "t6a_rd0");
    check("t6a_pre_ovf", 32'(bus.Rx_Overflow), 32'h1);
    async_reset("t6a_rst");

    // Test 6b: async reset mid-frame leaves no partial frame
    for (int i = 0; i < 10; i++) send_byte(8'hF0 + 8'(i));
    async_reset("t6b_rst");
    send_byte(8'hE0);
    send_byte(8'hE1);
    send_byte(8'hE2);
    send_eof();
    check_status("t6b_eof", 1'b1, 8'd1, 1'b0);
    read_exp(8'hE0, "t6b_rd0");
    check("t6b_done_ready", 32'(bus.Rx_Ready), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_frame_buffer.md
Name: hdlc_rx_frame_buffer

Overview:
Parametrised receive frame buffer for the HDLC controller. It sits between the Rx byte assembler/frame detector and the register interface. It stores one frame's bytes, strips the trailing FCS bytes from the reported length, and flags overflow. It then presents the frame for byte-wise readout with drop, abort and error discard. It generalises the fixed 128-byte, 8-bit Rx buffer to configurable width, depth and FCS length, and adds loss detection while a frame is pending.

Parameters:
DATA_W, 8, byte width of stored words
DEPTH, 128, maximum stored words per frame
FCS_BYTES, 2, trailing words excluded from reported frame size (0 allowed)
SIZE_W, $clog2(DEPTH+1), width of size/count signals

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  reset, asynchronous, active-high
Rx_NewByte  in  1  one-cycle strobe: Rx_Data valid
Rx_Data  in  DATA_W  received word
Rx_EoF  in  1  one-cycle strobe: closing flag detected
Rx_FrameError  in  1  one-cycle strobe: FCS/alignment error, discard frame
Rx_AbortSignal  in  1  one-cycle strobe: abort sequence received, discard frame
Rx_Drop  in  1  software drop of pending frame
Rx_RdBuff  in  1  read strobe for next stored word
Rx_DataBuff  out  DATA_W  read data, registered
Rx_Ready  out  1  complete frame available
Rx_FrameSize  out  SIZE_W  payload words of pending frame (count minus FCS_BYTES)
Rx_Overflow  out  1  sticky: words lost

Behaviour:
- Reset (async, Rst=1): state FILL, wptr/rptr/count=0, Rx_Ready=0, Rx_FrameSize=0, Rx_DataBuff=0, Rx_Overflow=0. Storage array is not reset.
- Reset mid-frame aborts everything immediately. No partial frame survives.
- States: FILL, READY.
- FILL, Rx_NewByte:
  - count<DEPTH: write mem[count], count++.
  - count==DEPTH: word discarded, Rx_Overflow<=1.
  - A write with count==0 clears Rx_Overflow. If the same cycle also overflows, set wins; this is only possible when DEPTH==0, which is illegal.
- FILL, Rx_EoF:
  - Evaluated on the count after any same-cycle write.
  - If final count>FCS_BYTES: Rx_FrameSize<=count-FCS_BYTES, Rx_Ready<=1 next cycle, go READY, rptr=0.
  - Otherwise: silent discard, count=0, stay FILL.
- FILL, Rx_FrameError or Rx_AbortSignal: count=0, stay FILL. Precedence over a same-cycle Rx_EoF. A same-cycle Rx_NewByte is not stored.
- An overflowed frame is still delivered at EoF, truncated: Rx_FrameSize=DEPTH-FCS_BYTES, Rx_Overflow stays 1.
- READY, Rx_RdBuff: Rx_DataBuff<=mem[rptr] (1-cycle latency), rptr++.
  - On the read with rptr==Rx_FrameSize-1: Rx_Ready<=0, Rx_FrameSize<=0, count=0, go FILL in that same edge.
- READY, Rx_Drop: Rx_Ready<=0, Rx_FrameSize<=0, count=0, go FILL. Rx_DataBuff unchanged. Drop wins over a same-cycle Rx_RdBuff.
- READY, Rx_NewByte: word discarded (single frame store), Rx_Overflow<=1.
- READY: Rx_EoF, Rx_FrameError and Rx_AbortSignal are ignored.
- Rx_RdBuff in FILL: ignored, Rx_DataBuff holds.
- Rx_Drop in FILL: ignored.
- Widths: count saturates at DEPTH, never wraps. Subtraction is only performed when count>FCS_BYTES.

Optional Feature:
Macro HDLC_RXBUF_FILL_LEVEL_EN.
- Defined: adds output Rx_FillLevel (SIZE_W), equal to registered count in FILL and 0 in READY. Also adds output Rx_AlmostFull, =1 when count>=DEPTH-4 in FILL.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package hdlc_rxbuf_pkg: state enum (RXB_FILL, RXB_READY); default constants RXB_DATA_W=8, RXB_DEPTH=128, RXB_FCS_BYTES=2, RXB_ALMOST_FULL_MARGIN=4.
- One sub-module, hdlc_rxbuf_ram: DEPTH x DATA_W register array, one synchronous write port, one registered read port, no reset on contents.

Test Plan (DEPTH=128, FCS_BYTES=2):
1. Bytes 0x11,0x22,0x33,0x44,0x55 then Rx_EoF -> next cycle Rx_Ready=1, Rx_FrameSize=3. Three Rx_RdBuff -> Rx_DataBuff 0x11,0x22,0x33, one cycle after each. Rx_Ready=0 after the third.
2. 130 bytes then Rx_EoF -> Rx_Overflow=1 at byte 129, Rx_FrameSize=126, first read 0 indexes byte 0. After readout, next frame's first byte -> Rx_Overflow=0.
3. 4 bytes then Rx_AbortSignal; then 2 bytes + Rx_EoF -> Rx_Ready stays 0 (discarded). Then 3 bytes 0xA0,0xA1,0xA2 + Rx_EoF -> Rx_FrameSize=1, read gives 0xA0.
4. Frame pending (size 3); Rx_Drop and Rx_RdBuff same cycle -> Rx_Ready=0 next cycle, Rx_DataBuff unchanged. Later Rx_RdBuff ignored.
5. Frame pending; one Rx_NewByte=0x7E -> Rx_Overflow=1, Rx_FrameSize unchanged, readout data intact.
6. Rst asserted asynchronously after 10 bytes -> all outputs 0 before the next edge. After release, 3 bytes + Rx_EoF -> Rx_FrameSize=1.
